pipe_fetch: RTL and testbench
=============================

# pipe_fetch

Instruction-fetch stage of the five-stage pipelined MIPS core inside `pipecomp`. It owns the program counter, drives the word address of the instruction ROM (`U_IM`), and loads the IF/ID pipeline register that feeds decode. It accepts a load-use stall from the hazard unit and a branch/jump redirect from the resolve stage. It also keeps a delivered-instruction counter that the board debug mux exposes through `reg_sel`/`reg_data`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `IM_AW`, default 8: word-address width of the instruction ROM.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold request from the hazard unit (load-use).
- `redirect`  in  1  a taken branch or jump has resolved this cycle.
- `redirect_pc`  in  32  target address for the redirect.
- `im_addr`  out  IM_AW  ROM word address, equal to `pc[IM_AW+1:2]`.
- `im_dout`  in  32  ROM read data, combinational from `im_addr`.
- `pc`  out  32  current fetch PC (register).
- `id_pc`  out  32  PC of the instruction held in IF/ID.
- `id_pc4`  out  32  `id_pc + 4`, registered.
- `id_instr`  out  32  instruction word held in IF/ID.
- `id_valid`  out  1  IF/ID holds a real instruction; 0 means bubble.
- `fetch_cnt`  out  32  number of valid instructions loaded into IF/ID.

## Operation
- Reset (`rstn`=0, takes effect immediately, no clock needed):
  - `pc` = RESET_PC.
  - `id_pc`, `id_pc4`, `id_instr`, `fetch_cnt` = 0.
  - `id_valid` = 0.
- Each rising edge, with the case priority **redirect > stall > advance**:
  - **Redirect** (`redirect`=1):
    - `pc` <= `{redirect_pc[31:2], 2'b00}`.
    - IF/ID <= bubble: `id_instr`=0 (sll NOP), `id_valid`=0, `id_pc`/`id_pc4`=0.
    - The wrong-path word fetched this cycle is discarded.
    - Redirect also overrides a simultaneous `stall`.
  - **Stall** (`stall`=1, `redirect`=0):
    - `pc` and every IF/ID field hold their values.
    - `fetch_cnt` holds.
  - **Advance** (neither asserted):
    - `pc` <= `pc + 4`.
    - `id_pc` <= `pc`.
    - `id_pc4` <= `pc + 4`.
    - `id_instr` <= `im_dout`.
    - `id_valid` <= 1.
    - `fetch_cnt` <= `fetch_cnt + 1`.
- Arithmetic:
  - `pc + 4` is modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
  - `fetch_cnt` wraps modulo 2^32.
- Address mapping: `im_addr` is truncated to IM_AW bits. PCs beyond the ROM alias; no fault is raised.
- `pc[1:0]` is always 00. The reset value RESET_PC must itself be word-aligned.

## Timing
- `im_addr` is combinational from the `pc` register. The ROM read completes within the same cycle.
- Fetch-to-decode latency is 1 edge. The word at PC P is visible on `id_instr` after the edge that follows the cycle in which `pc`=P.
- Redirect penalty:
  - Exactly one bubble: the edge that samples `redirect` loads the bubble.
  - The target instruction appears in IF/ID on the next edge (assuming no stall).
- Stall of N consecutive cycles freezes `pc` and IF/ID for N edges. Fetch resumes on the first edge where `stall`=0.
- Reset mid-operation:
  - Asynchronous assertion clears state immediately, discarding any in-flight stall or redirect.
  - After deassertion, the first edge fetches RESET_PC.
- `stall` and `redirect` must be stable before the rising edge. No internal synchronisation is performed.

## Test plan
1. **Reset and straight-line fetch.** ROM word k = 32'h2000_0000+k. Pulse `rstn` low for 20 ns, release, run 4 edges.
   - Required: `pc` = 0x0, 0x4, 0x8, 0xC, 0x10.
   - Required: `id_instr` = 0x2000_0000..0x2000_0003 on successive edges, `id_valid`=1, `fetch_cnt`=4.
2. **Stall.** At `pc`=0x8, hold `stall`=1 for 2 edges.
   - Required: `pc` stays 0x8; `id_pc` stays 0x4; `id_instr` stays 0x2000_0001; `fetch_cnt` unchanged.
   - Required: on release, the next edge loads `id_pc`=0x8.
3. **Redirect.** At `pc`=0xC, assert `redirect` with `redirect_pc`=0x40.
   - Required, next edge: `pc`=0x40, `id_valid`=0, `id_instr`=0.
   - Required, following edge: `id_pc`=0x40, `id_instr`=0x2000_0010, `id_valid`=1.
4. **Priority.** Assert `redirect` (`redirect_pc`=0x23) together with `stall`.
   - Required: `pc`=0x20 (misaligned bits dropped), IF/ID loads a bubble, `fetch_cnt` does not increment.
5. **Wrap.** Force `pc` to 0xFFFF_FFFC via a redirect, then advance.
   - Required: `pc`=0x0; `id_pc4`=0x0; `im_addr` aliases to 0xFF, then 0x00, with IM_AW=8.
6. **Reset mid-stall.** Drop `rstn` while `stall`=1 at `pc`=0x14.
   - Required, immediately (before any edge): `pc`=0, `id_valid`=0, `fetch_cnt`=0.

Source files
------------

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID register. Redirect outranks stall, and stall outranks advance.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [IM_AW-1:0]  im_addr,
  input  logic [31:0]       im_dout,
  output logic [31:0]       pc,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  output logic [31:0]       id_instr,
  output logic              id_valid,
  output logic [31:0]       fetch_cnt
);

  // Sequential PC step. The sum is taken modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Clears the byte-offset bits so that every target is word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_pc4_next;
  logic [31:0] id_instr_next;
  logic        id_valid_next;
  logic [31:0] fetch_cnt_next;

  assign pc4     = pc_inc(pc);
  // The ROM is indexed by word. Upper PC bits are dropped, so PCs past the ROM alias.
  assign im_addr = pc[IM_AW+1:2];

  // Next-state selection. The default holds every register, which covers the stall case.
  always_comb begin
    pc_next        = pc;
    id_pc_next     = id_pc;
    id_pc4_next    = id_pc4;
    id_instr_next  = id_instr;
    id_valid_next  = id_valid;
    fetch_cnt_next = fetch_cnt;
    if (redirect) begin
      // The wrong-path word on im_dout is dropped. IF/ID gets an sll NOP bubble.
      pc_next       = word_align(redirect_pc);
      id_pc_next    = 32'h0000_0000;
      id_pc4_next   = 32'h0000_0000;
      id_instr_next = 32'h0000_0000;
      id_valid_next = 1'b0;
    end else if (!stall) begin
      pc_next        = pc4;
      id_pc_next     = pc;
      id_pc4_next    = pc4;
      id_instr_next  = im_dout;
      id_valid_next  = 1'b1;
      fetch_cnt_next = fetch_cnt + 32'd1;
    end
  end

  // Holds the PC, IF/ID and delivered-count registers. Reset clears them asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc        <= RESET_PC;
      id_pc     <= 32'h0000_0000;
      id_pc4    <= 32'h0000_0000;
      id_instr  <= 32'h0000_0000;
      id_valid  <= 1'b0;
      fetch_cnt <= 32'h0000_0000;
    end else begin
      pc        <= pc_next;
      id_pc     <= id_pc_next;
      id_pc4    <= id_pc4_next;
      id_instr  <= id_instr_next;
      id_valid  <= id_valid_next;
      fetch_cnt <= fetch_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_fetch.sv
// Testbench for pipe_fetch. A reference model pushes the expected state for
// each driven cycle into a queue. That entry is popped and compared after the edge.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc, id_pc, id_pc4, id_instr, fetch_cnt;
  logic        id_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr, m_cnt;
  logic        m_valid;

  pipe_fetch #(.RESET_PC(32'h0000_0000), .IM_AW(8)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_addr(im_addr), .im_dout(im_dout),
    .pc(pc), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // The ROM returns 0x2000_0000 plus the word index k.
  assign im_dout = 32'h2000_0000 + {24'h0, im_addr};

  function automatic logic [31:0] rom_word(input logic [31:0] p);
    return 32'h2000_0000 + {24'h0, p[9:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0;
    m_id_instr = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00};
      m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_instr = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_id_pc    = m_pc;
      m_id_pc4   = m_pc + 32'd4;
      m_id_instr = rom_word(m_pc);
      m_valid    = 1'b1;
      m_cnt      = m_cnt + 32'd1;
      m_pc       = m_pc + 32'd4;
    end
    e.pc = m_pc; e.id_pc = m_id_pc; e.id_pc4 = m_id_pc4;
    e.id_instr = m_id_instr; e.id_valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("id_pc", id_pc, e.id_pc);
      check("id_pc4", id_pc4, e.id_pc4);
      check("id_instr", id_instr, e.id_instr);
      check("id_valid", {31'h0, id_valid}, {31'h0, e.id_valid});
      check("fetch_cnt", fetch_cnt, e.cnt);
      check("im_addr", {24'h0, im_addr}, {24'h0, e.pc[9:2]});
    end
  endtask

  // Drives one cycle of inputs, lets the edge happen, then samples 1 ns later.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    model_push(st, rd, rpc);
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_pc4"}, id_pc4, 32'h0);
    check({tag, "_id_instr"}, id_instr, 32'h0);
    check({tag, "_id_valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #20;
    check_reset_state("rst");
    model_reset();
    rstn = 1'b1;
    #1;
  endtask

  logic [31:0] cnt_hold;

  initial begin
    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #20;
    check_reset_state("por");
    rstn = 1'b1;

    // Straight-line fetch
    step(0, 0, 0); check("t1_pc1", pc, 32'h4); check("t1_ins0", id_instr, 32'h2000_0000);
    step(0, 0, 0); check("t1_pc2", pc, 32'h8); check("t1_ins1", id_instr, 32'h2000_0001);
    step(0, 0, 0); check("t1_pc3", pc, 32'hC); check("t1_ins2", id_instr, 32'h2000_0002);
    step(0, 0, 0); check("t1_pc4", pc, 32'h10); check("t1_ins3", id_instr, 32'h2000_0003);
    check("t1_valid", {31'h0, id_valid}, 32'h1);
    check("t1_cnt", fetch_cnt, 32'd4);

    // Stall at pc=0x8
    do_reset();
    step(0, 0, 0); step(0, 0, 0);
    cnt_hold = fetch_cnt;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      check("t2_pc", pc, 32'h8);
      check("t2_id_pc", id_pc, 32'h4);
      check("t2_instr", id_instr, 32'h2000_0001);
      check("t2_cnt", fetch_cnt, cnt_hold);
    end
    step(0, 0, 0); check("t2_release", id_pc, 32'h8);

    // Redirect at pc=0xC to 0x40
    check("t3_pre", pc, 32'hC);
    step(0, 1, 32'h40);
    check("t3_pc", pc, 32'h40);
    check("t3_bubble_v", {31'h0, id_valid}, 32'h0);
    check("t3_bubble_i", id_instr, 32'h0);
    step(0, 0, 0);
    check("t3_id_pc", id_pc, 32'h40);
    check("t3_instr", id_instr, 32'h2000_0010);
    check("t3_valid", {31'h0, id_valid}, 32'h1);

    // Redirect together with stall: the redirect wins and the PC is aligned
    cnt_hold = fetch_cnt;
    step(1, 1, 32'h23);
    check("t4_pc", pc, 32'h20);
    check("t4_valid", {31'h0, id_valid}, 32'h0);
    check("t4_cnt", fetch_cnt, cnt_hold);

    // Wrap around the top of the address space
    step(0, 1, 32'hFFFF_FFFC);
    check("t5_alias_ff", {24'h0, im_addr}, 32'hFF);
    step(0, 0, 0);
    check("t5_pc", pc, 32'h0);
    check("t5_pc4", id_pc4, 32'h0);
    check("t5_alias_00", {24'h0, im_addr}, 32'h00);
    check("t5_instr", id_instr, 32'h2000_00FF);

    // Reset asserted during a stall at pc=0x14
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check("t6_pre", pc, 32'h14);
    step(1, 0, 0);
    #3;
    rstn = 1'b0;
    #1;
    check("t6_pc", pc, 32'h0);
    check("t6_valid", {31'h0, id_valid}, 32'h0);
    check("t6_cnt", fetch_cnt, 32'h0);
    model_reset();
    stall = 1'b0;
    #2;
    rstn = 1'b1;
    step(0, 0, 0);
    check("t6_first", id_pc, 32'h0);

    // Random mix of stalls and occasional redirects
    for (int i = 0; i < 300; i++) begin
      logic s, r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      step(s, r, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
